// File: rtl/eth_rx_framer.sv
// -----------------------------------------------------------------------------
// eth_rx_framer
//
// Ethernet receive framer. Samples one PHY symbol per m_clock edge, hunts for
// the preamble/SFD, assembles payload bytes (first symbol = low bits), checks
// length / receive errors / dribble, and buffers the frame in a show-ahead byte
// FIFO presented as a valid/ready stream with last/err flags.
//
// Optional feature: define ETH_RX_CRC_EN to check the FCS with a reflected
// CRC-32 (residue 0xDEBB20E3). Undefined, the FCS is passed through unchecked.
//
// Parameters:
//   PHY_W      symbol width: 2 (RMII), 4 (MII), 8 (GMII)
//   FIFO_DEPTH byte FIFO entries, power of 2, >= 4
//   MIN_LEN    minimum frame bytes after SFD (FCS included)
//   MAX_LEN    maximum frame bytes after SFD (FCS included)
//
// Ports:
//   m_clock    sole clock
//   p_reset    synchronous active-low reset
//   rx_dv      PHY data valid
//   rx_er      PHY receive error
//   rxd        PHY data symbol
//   out_valid  FIFO head valid
//   out_ready  consumer accepts head
//   out_data   head byte
//   out_last   head is last byte of its frame
//   out_err    frame bad (meaningful with out_last)
//   busy       framer is in PREAMBLE or DATA
//   frame_cnt  good frames written (wrapping)
//   drop_cnt   bad / empty frames (wrapping)
// -----------------------------------------------------------------------------
module eth_rx_framer #(
  parameter int PHY_W      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [PHY_W-1:0] rxd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int SYMS = 8 / PHY_W;
  localparam int SC_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int BC_W = $clog2(MAX_LEN + 2);

  localparam logic [SC_W-1:0] SYM_LAST  = SC_W'(SYMS - 1);
  localparam logic [BC_W-1:0] MAX_CNT   = BC_W'(MAX_LEN);
  localparam logic [BC_W-1:0] MIN_CNT   = BC_W'(MIN_LEN);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE_LEFT  = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_DISCARD  = 2'd0,
    S_IDLE     = 2'd1,
    S_PREAMBLE = 2'd2,
    S_DATA     = 2'd3
  } state_e;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [SC_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            mem_q [FIFO_DEPTH];

  logic              do_push;
  entry_t            push_entry;
  logic              frame_end;
  logic              frame_bad;
  logic              pop;
  logic              crc_bad;
  entry_t            head;

  // ---------------------------------------------------------------------------
  // Optional FCS check: reflected CRC-32, one bit per received data bit.
  // ---------------------------------------------------------------------------
`ifdef ETH_RX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_next;

  always_comb begin
    crc_next = crc_q;
    for (int i = 0; i < PHY_W; i++) begin
      if (crc_next[0] ^ rxd[i]) crc_next = (crc_next >> 1) ^ 32'hEDB8_8320;
      else                      crc_next = crc_next >> 1;
    end
  end

  assign crc_bad = (crc_q != 32'hDEBB_20E3);
`else
  assign crc_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO read side (show-ahead). Outputs read as zero while empty.
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_last  = out_valid & head.last;
  assign out_err   = out_valid & head.err;

  assign busy      = (state_q == S_PREAMBLE) || (state_q == S_DATA);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sym_cnt_d   = sym_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef ETH_RX_CRC_EN
    crc_d       = crc_q;
`endif
    do_push         = 1'b0;
    push_entry      = '0;
    push_entry.data = stage_q;
    frame_end       = 1'b0;
    frame_bad       = 1'b0;

    // New symbols enter at the top so the first symbol ends up in the low bits.
    if (rx_dv) sr_d = 8'({rxd, sr_q} >> PHY_W);

    unique case (state_q)
      S_DISCARD: begin
        if (!rx_dv) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rx_dv) state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rx_er) begin
          state_d = S_DISCARD;
        end else if (sr_d == 8'hD5) begin
          state_d     = S_DATA;
          sym_cnt_d   = '0;
          byte_cnt_d  = '0;
          stage_vld_d = 1'b0;
`ifdef ETH_RX_CRC_EN
          crc_d       = '1;
`endif
        end
      end
      S_DATA: begin
        if (!rx_dv) begin
          // End of frame: flush the staged byte as the last entry.
          frame_end = 1'b1;
          state_d   = S_IDLE;
          frame_bad = (sym_cnt_q != '0) || (byte_cnt_q < MIN_CNT) || crc_bad;
          if (stage_vld_q) begin
            do_push         = 1'b1;
            push_entry.last = 1'b1;
            push_entry.err  = frame_bad;
          end else begin
            frame_bad = 1'b1;
          end
        end else if (rx_er) begin
          frame_end = 1'b1;
          frame_bad = 1'b1;
          state_d   = S_DISCARD;
          if (stage_vld_q) begin
            do_push         = 1'b1;
            push_entry.last = 1'b1;
            push_entry.err  = 1'b1;
          end
        end else begin
`ifdef ETH_RX_CRC_EN
          crc_d = crc_next;
`endif
          if (sym_cnt_q == SYM_LAST) begin
            sym_cnt_d = '0;
            if (byte_cnt_q == MAX_CNT) begin
              // Byte MAX_LEN+1 arrived: the staged byte closes the frame as bad.
              frame_end       = 1'b1;
              frame_bad       = 1'b1;
              state_d         = S_DISCARD;
              do_push         = stage_vld_q;
              push_entry.last = 1'b1;
              push_entry.err  = 1'b1;
            end else begin
              // The one-byte staging delay lets the final byte carry last=1.
              do_push     = stage_vld_q;
              stage_d     = sr_d;
              stage_vld_d = 1'b1;
              byte_cnt_d  = byte_cnt_q + BC_W'(1);
            end
          end else begin
            sym_cnt_d = sym_cnt_q + SC_W'(1);
          end
        end
      end
      default: state_d = S_DISCARD;
    endcase

    // Overflow guard on registered occupancy: the last free slot terminates
    // the frame as bad, and a full FIFO accepts nothing.
    if (do_push && (count_q == DEPTH_CNT)) begin
      do_push   = 1'b0;
      frame_end = 1'b1;
      frame_bad = 1'b1;
    end else if (do_push && (count_q == ONE_LEFT)) begin
      push_entry.last = 1'b1;
      push_entry.err  = 1'b1;
      frame_end       = 1'b1;
      frame_bad       = 1'b1;
    end

    if (frame_end) begin
      stage_vld_d = 1'b0;
      if (state_d == S_DATA) state_d = S_DISCARD;
      if (frame_bad) drop_cnt_d  = drop_cnt_q + 16'd1;
      else           frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(do_push) - CW'(pop);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_q     <= S_DISCARD;
      sr_q        <= '0;
      sym_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef ETH_RX_CRC_EN
      crc_q       <= '1;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sym_cnt_q   <= sym_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef ETH_RX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the head is only visible
  // through out_valid, which derives from the reset occupancy count.
  always_ff @(posedge m_clock) begin
    if (p_reset && do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_framer
//
// Directed bench for eth_rx_framer (PHY_W=4, FIFO_DEPTH=16, MIN_LEN=64,
// MAX_LEN=1518). Frames are built in frm[], sent nibble by nibble, and the
// accepted output beats are captured and compared against frm[].
// -----------------------------------------------------------------------------
module tb_eth_rx_framer;

`ifdef ETH_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_err;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  eth_rx_framer #(
    .PHY_W(4), .FIFO_DEPTH(16), .MIN_LEN(64), .MAX_LEN(1518)
  ) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .rxd      (rxd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_err  (out_err),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 m_clock = ~m_clock;

  int         checks = 0;
  int         failures = 0;
  int         exp_frames = 0;
  int         exp_drops = 0;
  logic [9:0] cap_q[$];          // {err, last, data} of each accepted beat
  logic [7:0] frm [0:1599];

  // Capture accepted beats away from the rising edge.
  always @(negedge m_clock) begin
    if (p_reset && out_valid && out_ready) cap_q.push_back({out_err, out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Payload i -> i mod 256; with CRC checking enabled, good frames carry a
  // correct FCS in their last four bytes.
  task automatic fill(input int n, input bit with_fcs);
    logic [31:0] fcs;
    for (int i = 0; i < n; i++) frm[i] = i[7:0];
    if (CRC_ON && with_fcs && n >= 4) begin
      fcs = ~crc_of(n - 4);
      for (int k = 0; k < 4; k++) frm[n - 4 + k] = fcs[8*k +: 8];
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next.
  task automatic drive(input logic dv, input logic er, input logic [3:0] d);
    @(posedge m_clock);
    #1;
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
  endtask

  // er_byte: byte index sent with rx_er=1 (-1 none).
  // rst_nib: data nibble index at which p_reset is pulled low for 2 edges (-1 none).
  task automatic send_frame(input int n, input bit dribble, input int er_byte, input int rst_nib);
    int nib = 0;
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < 2; h++) begin
        drive(1'b1, (i == er_byte), (h == 1) ? frm[i][7:4] : frm[i][3:0]);
        if (nib == 0) check("busy_in_frame", busy, 1);
        if (nib == rst_nib) p_reset = 1'b0;
        if (rst_nib >= 0 && nib == rst_nib + 2) begin
          p_reset = 1'b1;
          cap_q.delete();
        end
        nib++;
      end
    end
    if (dribble) drive(1'b1, 1'b0, 4'hA);
    repeat (4) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (out_valid && n < 200) begin
      @(negedge m_clock);
      n++;
    end
    check({tag, "_drain_in_time"}, (n < 200), 1);
  endtask

  task automatic check_frame(input string tag, input int n_exp, input logic exp_err);
    int bad = 0;
    wait_drain(tag);
    check({tag, "_beats"}, cap_q.size(), n_exp);
    for (int i = 0; i < cap_q.size() && i < n_exp; i++) begin
      if (cap_q[i][7:0] !== frm[i]) bad++;
      else if (cap_q[i][8] !== (i == n_exp - 1)) bad++;
      else if (i != n_exp - 1 && cap_q[i][9] !== 1'b0) bad++;
    end
    check({tag, "_beat_mismatches"}, bad, 0);
    if (cap_q.size() > 0) check({tag, "_last_err"}, cap_q[cap_q.size() - 1][9], exp_err);
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    check({tag, "_drop_cnt"}, drop_cnt, exp_drops);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_empty"}, out_valid, 0);
    cap_q.delete();
  endtask

  initial begin
    // Reset: everything zero.
    repeat (3) @(posedge m_clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    p_reset = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 4'h0);

    // Good 64-byte frame.
    fill(64, 1'b1);
    send_frame(64, 1'b0, -1, -1);
    exp_frames++;
    check_frame("good64", 64, 1'b0);

    // Runt: 60 bytes.
    fill(60, 1'b0);
    send_frame(60, 1'b0, -1, -1);
    exp_drops++;
    check_frame("short60", 60, 1'b1);

    // rx_er during byte 10 of a 100-byte frame.
    fill(100, 1'b0);
    send_frame(100, 1'b0, 10, -1);
    exp_drops++;
    check_frame("rx_er", 10, 1'b1);

    // Consumer stalled: FIFO fills, 16th entry closes the frame as bad.
    out_ready = 1'b0;
    fill(64, 1'b1);
    send_frame(64, 1'b0, -1, -1);
    check("stall_valid", out_valid, 1);
    check("stall_no_beats", cap_q.size(), 0);
    out_ready = 1'b1;
    exp_drops++;
    check_frame("overflow", 16, 1'b1);

    // Dribble nibble after 64 full bytes.
    fill(64, 1'b1);
    send_frame(64, 1'b1, -1, -1);
    exp_drops++;
    check_frame("dribble", 64, 1'b1);

    // Oversize: 1519 bytes.
    fill(1519, 1'b0);
    send_frame(1519, 1'b0, -1, -1);
    exp_drops++;
    check_frame("too_long", 1518, 1'b1);

`ifdef ETH_RX_CRC_EN
    // Corrupted FCS coverage.
    fill(64, 1'b1);
    frm[5] = frm[5] ^ 8'h01;
    send_frame(64, 1'b0, -1, -1);
    exp_drops++;
    check_frame("crc_bad", 64, 1'b1);
`endif

    // Reset pulse mid-frame with rx_dv held high: nothing output or counted.
    fill(40, 1'b0);
    send_frame(40, 1'b0, -1, 20);
    exp_frames = 0;
    exp_drops  = 0;
    check("rst_mid_no_beats", cap_q.size(), 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_drop_cnt", drop_cnt, 0);
    cap_q.delete();

    // The following frame is received normally.
    fill(64, 1'b1);
    send_frame(64, 1'b0, -1, -1);
    exp_frames++;
    check_frame("after_rst", 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
- Parametrised Ethernet receive framer; successor to the bare receiver shell.
- Samples PHY receive symbols (MII/RMII/GMII widths selected by PHY_W), strips preamble/SFD and assembles bytes.
- Checks length and receive errors and buffers the frame in a byte FIFO.
- Presents the frame as a valid/ready byte stream with last/err flags to the snx bus-side DMA/CPU logic.

Parameters:
- PHY_W, 4, symbol width per cycle; legal 2 (RMII), 4 (MII), 8 (GMII).
- FIFO_DEPTH, 16, byte FIFO entries; power of 2, >=4.
- MIN_LEN, 64, minimum frame bytes after SFD, FCS included.
- MAX_LEN, 1518, maximum frame bytes after SFD, FCS included.

Ports:
- m_clock  in  1  sole clock; one PHY symbol sampled per rising edge.
- p_reset  in  1  synchronous, active-low reset.
- rx_dv  in  1  PHY data valid.
- rx_er  in  1  PHY receive error.
- rxd  in  PHY_W  PHY data; first symbol of a byte carries byte bits [PHY_W-1:0].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  8  head byte.
- out_last  out  1  head is last byte of frame.
- out_err  out  1  frame bad; meaningful only when out_last=1.
- busy  out  1  state is PREAMBLE or DATA.
- frame_cnt  out  16  good frames written; wraps at 65535->0.
- drop_cnt  out  16  bad/empty frames; wraps at 65535->0.

Behaviour:
- Reset (p_reset=0 at edge): FIFO empty, staging empty, counters 0, all outputs 0, state DISCARD.
- Shift register sr[7:0] <= {rxd, sr[7:PHY_W]} each cycle rx_dv=1.
- DISCARD: wait for rx_dv=0, then IDLE. Reset therefore never starts mid-frame; a frame in flight at reset release is ignored and not counted.
- IDLE: rx_dv=1 -> PREAMBLE.
- PREAMBLE:
  - rx_dv=0 -> IDLE, no count.
  - rx_er=1 -> DISCARD, no count.
  - sr==0xD5 after shift -> DATA, byte count 0, symbol count 0.
- DATA:
  - Every 8/PHY_W symbols a byte completes.
  - A completed byte goes to the 1-byte staging register. The previous staged byte, if any, is pushed with last=0.
  - Push when FIFO free slots==1: entry written last=1, err=1; drop_cnt+1; -> DISCARD. FIFO never overflows.
  - Completing byte MAX_LEN+1: staged byte pushed last=1, err=1; drop_cnt+1; -> DISCARD.
  - rx_er=1: staged byte pushed last=1, err=1 (nothing pushed if staging empty); drop_cnt+1; -> DISCARD.
  - rx_dv falls: staged byte pushed last=1. err=1 if any of:
    - partial byte (dribble);
    - byte count < MIN_LEN;
    - CRC fail (see Optional Feature).
  - Closing counters at rx_dv fall: frame_cnt+1 if err=0, else drop_cnt+1. Staging empty (zero bytes) -> nothing pushed, drop_cnt+1. Then -> IDLE.
- FIFO: show-ahead, entries {err,last,data}.
  - out_valid = !empty; pop on out_valid & out_ready.
  - Simultaneous push/pop is legal; occupancy is unchanged.
  - Free-slot test uses registered occupancy before that cycle's pop.
- Latency: byte k appears on out_valid one cycle after byte k+1 completes, or one cycle after the rx_dv fall for the last byte.
- Outputs are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ETH_RX_CRC_EN.
- Defined:
  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF at SFD, no final xor.
  - Updated per received bit over all bytes after SFD, including FCS.
  - At rx_dv fall, register != 0xDEBB20E3 -> err=1 on the last entry.
- Undefined: FCS passed through unchecked; no CRC logic instantiated.

Test Plan (PHY_W=4, FIFO_DEPTH=16, MIN_LEN=64, MAX_LEN=1518):
- Stimulus: 7x0x55, 0xD5, 64 bytes 0x00..0x3F, rx_dv drop, out_ready=1. Response: 64 beats 0x00..0x3F; last on 0x3F, err=0; frame_cnt=1, drop_cnt=0.
- Stimulus: same framing, 60 bytes. Response: 60 beats, last err=1, drop_cnt=1. With ETH_RX_CRC_EN: 64-byte frame with valid FCS -> err=0; flip 1 bit -> err=1.
- Stimulus: 100-byte frame, rx_er asserted during byte index 10. Response: beats 0..9, last on byte 9, err=1, no further beats until the next SFD after rx_dv low.
- Stimulus: out_ready=0, 64-byte frame. Response: 16 entries, bytes 0..15, last on byte 15 with err=1; drop_cnt=1. Then out_ready=1: all 16 drain, out_valid=0.
- Stimulus: frame ends after an odd nibble count (dribble). Response: last err=1. Stimulus: 1519-byte frame. Response: 1518 beats, last on byte 1517 with err=1.
- Stimulus: p_reset=0 for 2 cycles mid-frame with rx_dv held high. Response: no output and no count until rx_dv low. A following 64-byte frame is received correctly.
